id_ex_reg: RTL and testbench

//   ID/EX pipeline register for the 5-stage exception-capable MIPS pipeline.

---
 rtl/id_ex_reg.sv | 96 +++++++++
 tb/tb_id_ex_reg.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: latches decoded operands, immediates, control and
// exception status at the end of ID, and forms the J-type target and link address.
module id_ex_reg #(
  parameter int CTRL_W = 16,
  parameter int EXC_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic [4:0]        id_rs_addr,
  input  logic [4:0]        id_rt_addr,
  input  logic [4:0]        id_rd_addr,
  input  logic [31:0]       id_imm32_l,
  input  logic [31:0]       id_imm32_h,
  input  logic [27:0]       id_imm28,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_exc_valid,
  input  logic [EXC_W-1:0]  id_exc_code,
  input  logic              id_in_dslot,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_rs_data,
  output logic [31:0]       ex_rt_data,
  output logic [4:0]        ex_rs_addr,
  output logic [4:0]        ex_rt_addr,
  output logic [4:0]        ex_rd_addr,
  output logic [31:0]       ex_imm32_l,
  output logic [31:0]       ex_imm32_h,
  output logic [31:0]       ex_jump_target,
  output logic [31:0]       ex_link_addr,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_exc_valid,
  output logic [EXC_W-1:0]  ex_exc_code,
  output logic              ex_in_dslot
);

  logic [3:0]        jump_hi;
  logic [31:0]       jump_target;
  logic [31:0]       link_addr;
  logic [CTRL_W-1:0] ctrl_next;
  logic              exc_valid_next;

  // (pc+4)[31:28] only differs from pc[31:28] when the +4 carries out of bit 27.
  always_comb begin
    jump_hi        = id_pc[31:28] + {3'b000, &id_pc[27:2]};
    jump_target    = {jump_hi, id_imm28};
    link_addr      = id_pc + 32'd8;
    // Bubbles and excepting instructions must not write registers or memory.
    ctrl_next      = (id_valid && !id_exc_valid) ? id_ctrl : '0;
    exc_valid_next = id_valid & id_exc_valid;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
      ex_rs_data     <= '0;
      ex_rt_data     <= '0;
      ex_rs_addr     <= '0;
      ex_rt_addr     <= '0;
      ex_rd_addr     <= '0;
      ex_imm32_l     <= '0;
      ex_imm32_h     <= '0;
      ex_jump_target <= '0;
      ex_link_addr   <= '0;
      ex_ctrl        <= '0;
      ex_exc_valid   <= 1'b0;
      ex_exc_code    <= '0;
      ex_in_dslot    <= 1'b0;
    end else if (!stall) begin
      ex_valid       <= id_valid;
      ex_pc          <= id_pc;
      ex_rs_data     <= id_rs_data;
      ex_rt_data     <= id_rt_data;
      ex_rs_addr     <= id_rs_addr;
      ex_rt_addr     <= id_rt_addr;
      ex_rd_addr     <= id_rd_addr;
      ex_imm32_l     <= id_imm32_l;
      ex_imm32_h     <= id_imm32_h;
      ex_jump_target <= jump_target;
      ex_link_addr   <= link_addr;
      ex_ctrl        <= ctrl_next;
      ex_exc_valid   <= exc_valid_next;
      ex_exc_code    <= id_exc_code;
      ex_in_dslot    <= id_in_dslot;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: vector table for capture behaviour plus
// hand-written reset, stall and flush sequences.
module tb_id_ex_reg;

  localparam int CTRL_W = 16;
  localparam int EXC_W  = 5;

  logic              clk = 1'b0;
  logic              rst, stall, flush;
  logic              id_valid;
  logic [31:0]       id_pc, id_rs_data, id_rt_data, id_imm32_l, id_imm32_h;
  logic [4:0]        id_rs_addr, id_rt_addr, id_rd_addr;
  logic [27:0]       id_imm28;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_exc_valid;
  logic [EXC_W-1:0]  id_exc_code;
  logic              id_in_dslot;
  logic              ex_valid;
  logic [31:0]       ex_pc, ex_rs_data, ex_rt_data, ex_imm32_l, ex_imm32_h;
  logic [4:0]        ex_rs_addr, ex_rt_addr, ex_rd_addr;
  logic [31:0]       ex_jump_target, ex_link_addr;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_exc_valid;
  logic [EXC_W-1:0]  ex_exc_code;
  logic              ex_in_dslot;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.CTRL_W(CTRL_W), .EXC_W(EXC_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_imm32_l(id_imm32_l), .id_imm32_h(id_imm32_h), .id_imm28(id_imm28),
    .id_ctrl(id_ctrl), .id_exc_valid(id_exc_valid), .id_exc_code(id_exc_code),
    .id_in_dslot(id_in_dslot),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_rd_addr(ex_rd_addr),
    .ex_imm32_l(ex_imm32_l), .ex_imm32_h(ex_imm32_h), .ex_jump_target(ex_jump_target),
    .ex_link_addr(ex_link_addr), .ex_ctrl(ex_ctrl), .ex_exc_valid(ex_exc_valid),
    .ex_exc_code(ex_exc_code), .ex_in_dslot(ex_in_dslot)
  );

  typedef struct {
    logic              valid;
    logic [31:0]       pc;
    logic [31:0]       rs_data;
    logic [31:0]       rt_data;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [4:0]        rd_addr;
    logic [31:0]       imm_l;
    logic [31:0]       imm_h;
    logic [27:0]       imm28;
    logic [CTRL_W-1:0] ctrl;
    logic              exc_v;
    logic [EXC_W-1:0]  exc_c;
    logic              dslot;
    // hand-computed expectations
    logic [CTRL_W-1:0] e_ctrl;
    logic              e_exc_v;
    logic [31:0]       e_jt;
    logic [31:0]       e_link;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid     = v.valid;
    id_pc        = v.pc;
    id_rs_data   = v.rs_data;
    id_rt_data   = v.rt_data;
    id_rs_addr   = v.rs_addr;
    id_rt_addr   = v.rt_addr;
    id_rd_addr   = v.rd_addr;
    id_imm32_l   = v.imm_l;
    id_imm32_h   = v.imm_h;
    id_imm28     = v.imm28;
    id_ctrl      = v.ctrl;
    id_exc_valid = v.exc_v;
    id_exc_code  = v.exc_c;
    id_in_dslot  = v.dslot;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"},  32'(ex_valid), 32'd0);
    check({tag, ".pc"},     ex_pc, 32'd0);
    check({tag, ".rs"},     ex_rs_data, 32'd0);
    check({tag, ".rt"},     ex_rt_data, 32'd0);
    check({tag, ".addrs"},  32'({ex_rs_addr, ex_rt_addr, ex_rd_addr}), 32'd0);
    check({tag, ".imm"},    ex_imm32_l | ex_imm32_h, 32'd0);
    check({tag, ".jt"},     ex_jump_target, 32'd0);
    check({tag, ".link"},   ex_link_addr, 32'd0);
    check({tag, ".ctrl"},   32'(ex_ctrl), 32'd0);
    check({tag, ".exc"},    32'({ex_exc_valid, ex_exc_code, ex_in_dslot}), 32'd0);
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check({tag, ".valid"},  32'(ex_valid), 32'(v.valid));
    check({tag, ".pc"},     ex_pc, v.pc);
    check({tag, ".rs"},     ex_rs_data, v.rs_data);
    check({tag, ".rt"},     ex_rt_data, v.rt_data);
    check({tag, ".addrs"},  32'({ex_rs_addr, ex_rt_addr, ex_rd_addr}),
                            32'({v.rs_addr, v.rt_addr, v.rd_addr}));
    check({tag, ".imm_l"},  ex_imm32_l, v.imm_l);
    check({tag, ".imm_h"},  ex_imm32_h, v.imm_h);
    check({tag, ".jt"},     ex_jump_target, v.e_jt);
    check({tag, ".link"},   ex_link_addr, v.e_link);
    check({tag, ".ctrl"},   32'(ex_ctrl), 32'(v.e_ctrl));
    check({tag, ".exc_v"},  32'(ex_exc_valid), 32'(v.e_exc_v));
    check({tag, ".exc_c"},  32'(ex_exc_code), 32'(v.exc_c));
    check({tag, ".dslot"},  32'(ex_in_dslot), 32'(v.dslot));
  endtask

  initial begin
    //          valid pc            rs_data       rt_data       rs  rt  rd  imm_l         imm_h         imm28         ctrl     exc_v exc_c dslot  e_ctrl   e_exc_v e_jt          e_link
    vecs[0] = '{1'b1, 32'h0040_0010, 32'h1111_1111, 32'h2222_2222, 5'd1, 5'd2, 5'd3, 32'h0000_0010, 32'h1234_0000, 28'h0ABC_DEF0, 16'h0003, 1'b0, 5'd0,  1'b0, 16'h0003, 1'b0, 32'h0ABC_DEF0, 32'h0040_0018};
    vecs[1] = '{1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'h0000_0001, 5'd31, 5'd0, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_0000, 28'h000_0040, 16'h0001, 1'b0, 5'd0,  1'b0, 16'h0001, 1'b0, 32'h0000_0040, 32'h0000_0004};
    vecs[2] = '{1'b1, 32'h1FFF_FFFC, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 5'd8, 5'd9, 5'd10, 32'h0000_001F, 32'h8000_0000, 28'h123_4568, 16'h00F0, 1'b0, 5'd0,  1'b1, 16'h00F0, 1'b0, 32'h2123_4568, 32'h2000_0004};
    vecs[3] = '{1'b1, 32'h8000_0180, 32'h0000_0100, 32'h0000_0200, 5'd4, 5'd5, 5'd6, 32'h0000_0004, 32'h0004_0000, 28'h000_0100, 16'h0001, 1'b1, 5'd10, 1'b1, 16'h0000, 1'b1, 32'h8000_0100, 32'h8000_0188};
    vecs[4] = '{1'b0, 32'h0000_1000, 32'h0BAD_F00D, 32'h0C0F_FEE0, 5'd12, 5'd13, 5'd14, 32'h0000_7FFF, 32'h7FFF_0000, 28'hFFF_FFFC, 16'hFFFF, 1'b1, 5'd3,  1'b0, 16'h0000, 1'b0, 32'h0FFF_FFFC, 32'h0000_1008};
    vecs[5] = '{1'b1, 32'hEFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFFF, 5'd16, 5'd17, 5'd18, 32'hFFFF_8000, 32'h8000_0000, 28'h000_0000, 16'h8002, 1'b0, 5'd0,  1'b0, 16'h8002, 1'b0, 32'hE000_0000, 32'hF000_0000};

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(vecs[0]);
    #1;
    check_zero("reset_async");
    @(posedge clk); #1;
    check_zero("reset_held");
    @(negedge clk); rst = 1'b0;

    // Table: one capture per vector, one-cycle latency.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); drive(vecs[i]);
      @(posedge clk); #1;
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset pulse between edges clears outputs without waiting for a clock.
    @(posedge clk); #3;
    rst = 1'b1; #1;
    check_zero("reset_mid");
    @(negedge clk); rst = 1'b0;

    // Stall for three edges with changing inputs; outputs stay frozen.
    @(negedge clk); drive(vecs[0]);
    @(posedge clk); #1;
    check_vec("pre_stall", vecs[0]);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); stall = 1'b1; drive(vecs[i]);
      @(posedge clk); #1;
      check_vec($sformatf("stall%0d", i), vecs[0]);
    end
    @(negedge clk); stall = 1'b0; drive(vecs[5]);
    @(posedge clk); #1;
    check_vec("stall_release", vecs[5]);

    // Flush wins over stall even with a valid instruction in ID.
    @(negedge clk); stall = 1'b1; flush = 1'b1; drive(vecs[2]);
    @(posedge clk); #1;
    check_zero("flush_stall");
    @(negedge clk); stall = 1'b0; flush = 1'b0; drive(vecs[3]);
    @(posedge clk); #1;
    check_vec("after_flush", vecs[3]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
